// File: rtl/contador_ctrl.sv
// Up/down 8-bit counter with manual, automatic-up, automatic-down and paused modes.
// Automatic steps are paced by an internal prescaler; overflow either wraps or saturates.
module contador_ctrl #(
  parameter int PRESCALE = 50000000,
  parameter int WRAP     = 1
) (
  input  logic       iClk,
  input  logic       iReset_n,
  input  logic       iPulsoInc,
  input  logic       iPulsoDec,
  input  logic       iPulsoClr,
  input  logic       iPulsoModo,
  output logic [7:0] oCuenta,
  output logic [1:0] oEstado,
  output logic       oTick,
  output logic       oDesborde
);

  typedef enum logic [1:0] {
    MANUAL    = 2'b00,
    AUTO_UP   = 2'b01,
    AUTO_DOWN = 2'b10,
    PAUSA     = 2'b11
  } estado_t;

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  estado_t       estado;
  estado_t       estado_sig;
  logic [PW-1:0] prescaler;
  logic          pre_fin;
  logic          at_max;
  logic          at_min;
  logic [7:0]    cuenta_up;
  logic [7:0]    cuenta_dn;
  logic          solo_inc;
  logic          solo_dec;

  // Step results are precomputed so the FSM only has to pick one; saturation
  // simply keeps the old value when the step would leave the 0..255 range.
  always_comb begin
    at_max    = (oCuenta == 8'hFF);
    at_min    = (oCuenta == 8'h00);
    cuenta_up = oCuenta + 8'd1;
    cuenta_dn = oCuenta - 8'd1;
    if (WRAP == 0 && at_max) cuenta_up = oCuenta;
    if (WRAP == 0 && at_min) cuenta_dn = oCuenta;
    pre_fin  = (prescaler == PRE_MAX);
    solo_inc = iPulsoInc && !iPulsoDec;
    solo_dec = iPulsoDec && !iPulsoInc;
  end

  always_comb begin
    estado_sig = MANUAL;
    unique case (estado)
      MANUAL:    estado_sig = AUTO_UP;
      AUTO_UP:   estado_sig = AUTO_DOWN;
      AUTO_DOWN: estado_sig = PAUSA;
      PAUSA:     estado_sig = MANUAL;
    endcase
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      estado    <= MANUAL;
      prescaler <= '0;
      oCuenta   <= 8'd0;
      oTick     <= 1'b0;
      oDesborde <= 1'b0;
    end else begin
      oTick     <= 1'b0;
      oDesborde <= 1'b0;
      if (iPulsoClr) begin
        oCuenta   <= 8'd0;
        prescaler <= '0;
      end else if (iPulsoModo) begin
        estado    <= estado_sig;
        prescaler <= '0;
      end else begin
        unique case (estado)
          MANUAL: begin
            prescaler <= '0;
            if (solo_inc) begin
              oCuenta   <= cuenta_up;
              oDesborde <= at_max;
            end else if (solo_dec) begin
              oCuenta   <= cuenta_dn;
              oDesborde <= at_min;
            end
          end
          // A direction request outranks the tick: the prescaler keeps running
          // but a step falling on that same edge is dropped.
          AUTO_UP, AUTO_DOWN: begin
            prescaler <= pre_fin ? '0 : prescaler + PW'(1);
            if (solo_inc) begin
              estado <= AUTO_UP;
            end else if (solo_dec) begin
              estado <= AUTO_DOWN;
            end else if (pre_fin) begin
              oTick <= 1'b1;
              if (estado == AUTO_UP) begin
                oCuenta   <= cuenta_up;
                oDesborde <= at_max;
              end else begin
                oCuenta   <= cuenta_dn;
                oDesborde <= at_min;
              end
            end
          end
          PAUSA: begin
          end
        endcase
      end
    end
  end

  assign oEstado = estado;

endmodule

// File: tb/tb_contador_ctrl.sv
// Bench for contador_ctrl: a wrapping and a saturating instance (PRESCALE=4) checked
// every cycle against an arithmetic model, plus directed literal expectations.
module tb_contador_ctrl;

  localparam int PRESCALE = 4;

  logic       iClk;
  logic       iReset_n;
  logic [1:0] inc, dec, clr, modo;
  logic [7:0] cuenta0, cuenta1;
  logic [1:0] estado0, estado1;
  logic       tick0, tick1, desb0, desb1;
  logic       check_en;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int mode;
    int count;
    int phase;
    bit tick;
    bit ovf;
  } model_t;

  model_t m0, m1;

  contador_ctrl #(.PRESCALE(PRESCALE), .WRAP(1)) u_wrap (
    .iClk(iClk), .iReset_n(iReset_n),
    .iPulsoInc(inc[0]), .iPulsoDec(dec[0]), .iPulsoClr(clr[0]), .iPulsoModo(modo[0]),
    .oCuenta(cuenta0), .oEstado(estado0), .oTick(tick0), .oDesborde(desb0)
  );

  contador_ctrl #(.PRESCALE(PRESCALE), .WRAP(0)) u_sat (
    .iClk(iClk), .iReset_n(iReset_n),
    .iPulsoInc(inc[1]), .iPulsoDec(dec[1]), .iPulsoClr(clr[1]), .iPulsoModo(modo[1]),
    .oCuenta(cuenta1), .oEstado(estado1), .oTick(tick1), .oDesborde(desb1)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  function automatic model_t model_reset();
    model_t r;
    r.mode = 0; r.count = 0; r.phase = 0; r.tick = 0; r.ovf = 0;
    return r;
  endfunction

  // Mode numbering: 0 manual, 1 auto up, 2 auto down, 3 paused.
  function automatic model_t advance(model_t m, bit i, bit d, bit c, bit md, bit wrap);
    model_t n;
    int dir;
    int raw;
    n = m;
    n.tick = 0;
    n.ovf = 0;
    dir = 0;
    if (c) begin
      n.count = 0;
      n.phase = 0;
    end else if (md) begin
      n.mode = (m.mode + 1) % 4;
      n.phase = 0;
    end else if (m.mode == 0) begin
      n.phase = 0;
      if (i != d) dir = i ? 1 : -1;
    end else if (m.mode == 1 || m.mode == 2) begin
      n.phase = (m.phase + 1) % PRESCALE;
      if (i && !d) n.mode = 1;
      else if (d && !i) n.mode = 2;
      else if (m.phase == PRESCALE - 1) begin
        n.tick = 1;
        dir = (m.mode == 1) ? 1 : -1;
      end
    end
    if (dir != 0) begin
      raw = m.count + dir;
      if (raw < 0 || raw > 255) begin
        n.ovf = 1;
        n.count = wrap ? (raw + 256) % 256 : m.count;
      end else begin
        n.count = raw;
      end
    end
    return n;
  endfunction

  always @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      m0 = model_reset();
      m1 = model_reset();
    end else begin
      m0 = advance(m0, inc[0], dec[0], clr[0], modo[0], 1'b1);
      m1 = advance(m1, inc[1], dec[1], clr[1], modo[1], 1'b0);
    end
  end

  task automatic checkOutput(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  always @(negedge iClk) begin
    if (check_en) begin
      checkOutput("wrap.cuenta", int'(cuenta0), m0.count);
      checkOutput("wrap.estado", int'(estado0), m0.mode);
      checkOutput("wrap.tick", int'(tick0), int'(m0.tick));
      checkOutput("wrap.desborde", int'(desb0), int'(m0.ovf));
      checkOutput("sat.cuenta", int'(cuenta1), m1.count);
      checkOutput("sat.estado", int'(estado1), m1.mode);
      checkOutput("sat.tick", int'(tick1), int'(m1.tick));
      checkOutput("sat.desborde", int'(desb1), int'(m1.ovf));
    end
  end

  // Called at a falling edge; holds the request for exactly one rising edge.
  task automatic applyStimulus(int u, bit i, bit d, bit c, bit md);
    inc[u] = i; dec[u] = d; clr[u] = c; modo[u] = md;
    @(negedge iClk);
    inc[u] = 1'b0; dec[u] = 1'b0; clr[u] = 1'b0; modo[u] = 1'b0;
  endtask

  initial begin
    check_en = 1'b0;
    iReset_n = 1'b0;
    inc = '0; dec = '0; clr = '0; modo = '0;
    @(negedge iClk);
    checkOutput("reset.cuenta", int'(cuenta0), 0);
    checkOutput("reset.estado", int'(estado0), 0);
    checkOutput("reset.tick", int'(tick0), 0);
    @(negedge iClk);
    iReset_n = 1'b1;
    check_en = 1'b1;

    // Manual mode on the wrapping instance
    repeat (3) applyStimulus(0, 1, 0, 0, 0);
    checkOutput("manual.inc3", int'(cuenta0), 3);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("manual.incdec", int'(cuenta0), 3);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("manual.clr", int'(cuenta0), 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("manual.dec_wrap", int'(cuenta0), 255);
    checkOutput("manual.dec_ovf", int'(desb0), 1);
    @(negedge iClk);
    checkOutput("manual.ovf_once", int'(desb0), 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("manual.dec254", int'(cuenta0), 254);

    // Automatic up across the 255->0 boundary
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("auto.estado_up", int'(estado0), 1);
    repeat (3) @(negedge iClk);
    checkOutput("auto.hold254", int'(cuenta0), 254);
    checkOutput("auto.no_tick", int'(tick0), 0);
    @(negedge iClk);
    checkOutput("auto.step255", int'(cuenta0), 255);
    checkOutput("auto.tick", int'(tick0), 1);
    @(negedge iClk);
    checkOutput("auto.tick_once", int'(tick0), 0);
    repeat (3) @(negedge iClk);
    checkOutput("auto.wrap0", int'(cuenta0), 0);
    checkOutput("auto.wrap_ovf", int'(desb0), 1);

    // Collisions with the tick edge
    repeat (4) @(negedge iClk);
    checkOutput("coll.pre_count", int'(cuenta0), 1);
    repeat (3) @(negedge iClk);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("coll.clr_count", int'(cuenta0), 0);
    checkOutput("coll.clr_estado", int'(estado0), 1);
    checkOutput("coll.clr_tick", int'(tick0), 0);
    repeat (3) @(negedge iClk);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("coll.modo_estado", int'(estado0), 2);
    checkOutput("coll.modo_count", int'(cuenta0), 0);
    checkOutput("coll.modo_tick", int'(tick0), 0);

    // Pause freezes everything
    repeat (2) @(negedge iClk);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("pausa.estado", int'(estado0), 3);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("pausa.inc_ignored", int'(cuenta0), 0);
    repeat (6) @(negedge iClk);
    checkOutput("pausa.frozen", int'(cuenta0), 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("pausa.to_manual", int'(estado0), 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("pausa.manual_inc", int'(cuenta0), 1);

    // Asynchronous reset while counting up from 37
    repeat (36) applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    repeat (2) @(negedge iClk);
    checkOutput("areset.pre_count", int'(cuenta0), 37);
    #2 iReset_n = 1'b0;
    #1;
    checkOutput("areset.cuenta", int'(cuenta0), 0);
    checkOutput("areset.estado", int'(estado0), 0);
    checkOutput("areset.tick", int'(tick0), 0);
    #1 iReset_n = 1'b1;
    @(negedge iClk);
    checkOutput("areset.resume", int'(estado0), 0);

    // Saturating instance counting down from 1
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("sat.estado_down", int'(estado1), 2);
    repeat (3) @(negedge iClk);
    checkOutput("sat.hold1", int'(cuenta1), 1);
    @(negedge iClk);
    checkOutput("sat.reach0", int'(cuenta1), 0);
    checkOutput("sat.reach0_ovf", int'(desb1), 0);
    repeat (4) @(negedge iClk);
    checkOutput("sat.held0", int'(cuenta1), 0);
    checkOutput("sat.clip_ovf", int'(desb1), 1);
    checkOutput("sat.clip_tick", int'(tick1), 1);
    @(negedge iClk);
    checkOutput("sat.ovf_once", int'(desb1), 0);
    repeat (3) @(negedge iClk);
    checkOutput("sat.clip_again", int'(desb1), 1);
    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(1, 0, 1, 0, 0);
    checkOutput("sat.manual_clip", int'(cuenta1), 0);
    checkOutput("sat.manual_ovf", int'(desb1), 1);

    repeat (2) @(negedge iClk);
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/contador_ctrl.md
CONTADOR_CTRL -- requirements
Module: contador_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 50000000, clocks per automatic count step (legal range >= 2).
REQ-002 SHALL have parameter WRAP, default 1, overflow policy: 1 = wrap-around, 0 = saturate.
REQ-003 SHALL have port iClk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port iReset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port iPulsoInc  input  1  one-cycle increment request, already synchronised and edge-detected upstream.
REQ-006 SHALL have port iPulsoDec  input  1  one-cycle decrement request, same origin.
REQ-007 SHALL have port iPulsoClr  input  1  one-cycle clear request, same origin.
REQ-008 SHALL have port iPulsoModo  input  1  one-cycle mode-advance request, same origin.
REQ-009 SHALL have port oCuenta  output  8  current count, registered.
REQ-010 SHALL have port oEstado  output  2  FSM state: 00 MANUAL, 01 AUTO_UP, 10 AUTO_DOWN, 11 PAUSA.
REQ-011 SHALL have port oTick  output  1  one-cycle pulse, registered, asserted the cycle after each automatic step.
REQ-012 SHALL have port oDesborde  output  1  one-cycle pulse, registered, asserted the cycle after any step that crosses 255->0 or 0->255 (or is clipped when WRAP=0).

Function
REQ-013 SHALL arbitrate requests per cycle with fixed priority Clr > Modo > Inc/Dec > automatic tick; lower-priority requests in the same cycle are discarded, not queued.
REQ-014 SHALL on iPulsoClr: oCuenta <= 0, prescaler <= 0, oEstado unchanged, no oTick, no oDesborde.
REQ-015 SHALL on iPulsoModo (no Clr): advance state MANUAL->AUTO_UP->AUTO_DOWN->PAUSA->MANUAL, prescaler <= 0, count unchanged.
REQ-016 SHALL in MANUAL: iPulsoInc alone -> count+1; iPulsoDec alone -> count-1; both in same cycle -> no change; prescaler held at 0.
REQ-017 SHALL in AUTO_UP/AUTO_DOWN: iPulsoInc alone -> state AUTO_UP, iPulsoDec alone -> state AUTO_DOWN, count unchanged, prescaler not reset; both -> ignored.
REQ-018 SHALL in AUTO_UP/AUTO_DOWN run prescaler 0..PRESCALE-1; on the edge where prescaler == PRESCALE-1 (and no higher-priority request): prescaler <= 0, count steps +1 (AUTO_UP) or -1 (AUTO_DOWN), oTick <= 1 for one cycle.
REQ-019 SHALL in PAUSA hold count and freeze prescaler value; iPulsoInc/iPulsoDec ignored.
REQ-020 SHALL size prescaler as $clog2(PRESCALE) bits; count arithmetic strictly 8-bit unsigned.
REQ-021 SHALL with WRAP=1: 255+1 -> 0 and 0-1 -> 255, oDesborde pulse.
REQ-022 SHALL with WRAP=0: 255+1 -> 255 and 0-1 -> 0 (held), oDesborde pulse on each clipped attempt.
REQ-023 SHALL have one-cycle latency: request sampled at edge N, new oCuenta/oEstado visible after edge N; oTick/oDesborde high exactly during cycle N+1.
REQ-024 SHALL never assert oTick or oDesborde for two consecutive cycles when PRESCALE >= 2 and inputs are single-cycle pulses.

Reset
REQ-025 SHALL on iReset_n low, immediately and without clock: oCuenta = 0, oEstado = 00 (MANUAL), prescaler = 0, oTick = 0, oDesborde = 0.
REQ-026 SHALL resume operation on the first rising iClk edge after iReset_n returns high; requests present during reset are lost.

Verification (bench uses PRESCALE=4)
REQ-027 SHALL verify async reset: in AUTO_UP with count 37, drop iReset_n between edges -> oCuenta=0, oEstado=00, oTick=0 before next edge.
REQ-028 SHALL verify MANUAL: 3 Inc pulses -> oCuenta=3; Inc+Dec same cycle -> stays 3; Clr, then Dec with WRAP=1 -> 255 and oDesborde high one cycle.
REQ-029 SHALL verify AUTO_UP wrap: count 254, Modo once -> 255 after 4 cycles, 0 after 8 with oDesborde; oTick every 4th cycle only.
REQ-030 SHALL verify WRAP=0 AUTO_DOWN from 1: 0 after 4 cycles, then held at 0 with oDesborde each following tick.
REQ-031 SHALL verify collisions: Clr+Modo+tick same cycle -> oCuenta=0, state unchanged, no oTick/oDesborde; Modo on tick cycle -> state advances, no step.
REQ-032 SHALL verify PAUSA: prescaler at 2, Modo to PAUSA, Inc ignored, count frozen; Modo -> MANUAL with prescaler 0.
